// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped, write-back data cache.
// Contents:
//   - default geometry (line count, line width)
//   - address field widths (byte offset, word select, line offset, index, tag)
//   - controller state encoding
//   - line_base(): clears the in-line offset of a byte address
package dcache_pkg;

    localparam int LINES_DEF     = 32;
    localparam int LINE_BITS_DEF = 256;

    localparam int ADDR_BITS     = 32;
    localparam int WORD_BITS     = 32;
    localparam int BYTE_OFF_BITS = 2;
    localparam int WORD_SEL_BITS = 3;
    localparam int LINE_OFF_BITS = BYTE_OFF_BITS + WORD_SEL_BITS;
    localparam int INDEX_BITS    = $clog2(LINES_DEF);
    localparam int TAG_BITS      = ADDR_BITS - LINE_OFF_BITS - INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // Line-aligned address of the line containing addr.
    function automatic logic [ADDR_BITS-1:0] line_base(input logic [ADDR_BITS-1:0] addr);
        return {addr[ADDR_BITS-1:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Cache data array: LINES x LINE_BITS, flop based.
// Ports:
//   clk       - write clock
//   rd_index  - line selected for the combinational read port
//   rd_data   - contents of the selected line
//   wr_en     - write enable for the line-wide write port
//   wr_index  - line written
//   wr_mask   - one bit per 32-bit word; only masked words are updated
//   wr_data   - line-wide write data (unmasked words ignored)
// Contents are not reset; validity is tracked by the controller.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES     = LINES_DEF,
    parameter int LINE_BITS = LINE_BITS_DEF
) (
    input  logic                     clk,
    input  logic [$clog2(LINES)-1:0] rd_index,
    output logic [LINE_BITS-1:0]     rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(LINES)-1:0] wr_index,
    input  logic [LINE_BITS/WORD_BITS-1:0] wr_mask,
    input  logic [LINE_BITS-1:0]     wr_data
);

    localparam int WORDS = LINE_BITS / WORD_BITS;

    logic [LINE_BITS-1:0] mem_r [LINES];

    // Asynchronous read so a hit can return data in the request cycle.
    assign rd_data = mem_r[rd_index];

    // Word-masked line write.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WORDS; w++) begin
            if (wr_en && wr_mask[w]) begin
                mem_r[wr_index][w*WORD_BITS +: WORD_BITS] <= wr_data[w*WORD_BITS +: WORD_BITS];
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   p1_req_i, p1_write_i  - CPU access request and store/load select
//   p1_addr_i, p1_data_i  - word-aligned byte address, store data
//   p1_data_o             - load data (same cycle on a hit, 0 otherwise)
//   p1_stall_o            - freezes the pipeline while a miss is serviced
//   mem_enable_o          - memory request valid
//   mem_write_o           - 1 = line write-back, 0 = line fetch
//   mem_addr_o            - line-aligned memory address
//   mem_data_o            - line being written back
//   mem_data_i, mem_ack_i - fetched line and one-cycle completion pulse
// Tags, valid and dirty bits live in flops here; line data in dcache_sram.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES     = LINES_DEF,
    parameter int LINE_BITS = LINE_BITS_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 p1_req_i,
    input  logic                 p1_write_i,
    input  logic [31:0]          p1_addr_i,
    input  logic [31:0]          p1_data_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = TAG_BITS + INDEX_BITS - IDX_W;
    localparam int WORDS = LINE_BITS / WORD_BITS;

    // Address fields
    logic [WORD_SEL_BITS-1:0] word_sel_s;
    logic [IDX_W-1:0]         index_s;
    logic [TAG_W-1:0]         tag_s;
    logic                     addr_unused_s;

    assign word_sel_s    = p1_addr_i[LINE_OFF_BITS-1:BYTE_OFF_BITS];
    assign index_s       = p1_addr_i[LINE_OFF_BITS +: IDX_W];
    assign tag_s         = p1_addr_i[ADDR_BITS-1 -: TAG_W];
    assign addr_unused_s = ^p1_addr_i[BYTE_OFF_BITS-1:0];

    // Controller state and line metadata
    state_t           state_r;
    state_t           next_state_s;
    logic [TAG_W-1:0] tag_r [LINES];
    logic [LINES-1:0] valid_r;
    logic [LINES-1:0] dirty_r;

    logic                 hit_s;
    logic                 victim_dirty_s;
    logic [WORDS-1:0]     word_mask_s;
    logic [LINE_BITS-1:0] rd_line_s;
    logic [31:0]          sel_word_s;
    logic [31:0]          victim_addr_s;

    logic                 sram_we_s;
    logic [WORDS-1:0]     sram_mask_s;
    logic [LINE_BITS-1:0] sram_wdata_s;
    logic                 fill_s;
    logic                 mark_dirty_s;

    logic                 mem_enable_r;
    logic                 mem_write_r;
    logic [31:0]          mem_addr_r;
    logic [LINE_BITS-1:0] mem_data_r;

    assign hit_s          = p1_req_i & valid_r[index_s] & (tag_r[index_s] == tag_s);
    assign victim_dirty_s = valid_r[index_s] & dirty_r[index_s];
    assign victim_addr_s  = {tag_r[index_s], index_s, {LINE_OFF_BITS{1'b0}}};

    // One-hot word select within the line.
    always_comb begin
        word_mask_s = '0;
        for (int w = 0; w < WORDS; w++) begin
            word_mask_s[w] = (word_sel_s == WORD_SEL_BITS'(w));
        end
    end

    // Selected word of the indexed line (AND-OR mux).
    always_comb begin
        sel_word_s = '0;
        for (int w = 0; w < WORDS; w++) begin
            sel_word_s = sel_word_s |
                (word_mask_s[w] ? rd_line_s[w*WORD_BITS +: WORD_BITS] : {WORD_BITS{1'b0}});
        end
    end

    // Stall and load data are combinational so a hit costs no cycle.
    assign p1_stall_o = (state_r != ST_IDLE) | (p1_req_i & ~hit_s);
    assign p1_data_o  = ((state_r == ST_IDLE) && hit_s) ? sel_word_s : 32'h0000_0000;

    // Next-state logic plus data-array write and metadata update controls.
    always_comb begin
        next_state_s = state_r;
        sram_we_s    = 1'b0;
        sram_mask_s  = '0;
        sram_wdata_s = '0;
        fill_s       = 1'b0;
        mark_dirty_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (p1_req_i && !hit_s) begin
                    next_state_s = victim_dirty_s ? ST_WRITEBACK : ST_REFILL;
                end else if (hit_s && p1_write_i) begin
                    // Store hit: merge one word, line becomes dirty.
                    sram_we_s    = 1'b1;
                    sram_mask_s  = word_mask_s;
                    sram_wdata_s = {WORDS{p1_data_i}};
                    mark_dirty_s = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack_i) begin
                    next_state_s = ST_REFILL;
                end else begin
                    next_state_s = ST_WRITEBACK;
                end
            end
            ST_REFILL: begin
                if (mem_ack_i) begin
                    sram_we_s    = 1'b1;
                    sram_mask_s  = '1;
                    sram_wdata_s = mem_data_i;
                    fill_s       = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_REFILL;
                end
            end
            // One extra stall cycle so the held request re-evaluates as a hit.
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Valid and dirty bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else if (fill_s) begin
            valid_r[index_s] <= 1'b1;
            dirty_r[index_s] <= 1'b0;
        end else if (mark_dirty_s) begin
            dirty_r[index_s] <= 1'b1;
        end
    end

    // Tag array; only meaningful where valid is set.
    always_ff @(posedge clk_i) begin
        if (fill_s) begin
            tag_r[index_s] <= tag_s;
        end
    end

    // Memory request outputs, registered against the state being entered so
    // they are stable for the whole request and drop the cycle after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_enable_r <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            mem_data_r   <= '0;
        end else begin
            case (next_state_s)
                ST_WRITEBACK: begin
                    mem_enable_r <= 1'b1;
                    mem_write_r  <= 1'b1;
                    mem_addr_r   <= victim_addr_s;
                    mem_data_r   <= rd_line_s;
                end
                ST_REFILL: begin
                    mem_enable_r <= 1'b1;
                    mem_write_r  <= 1'b0;
                    mem_addr_r   <= line_base(p1_addr_i);
                    mem_data_r   <= '0;
                end
                default: begin
                    mem_enable_r <= 1'b0;
                    mem_write_r  <= 1'b0;
                    mem_addr_r   <= 32'h0000_0000;
                    mem_data_r   <= '0;
                end
            endcase
        end
    end

    assign mem_enable_o = mem_enable_r;
    assign mem_write_o  = mem_write_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_data_o   = mem_data_r;

    dcache_sram #(
        .LINES     (LINES),
        .LINE_BITS (LINE_BITS)
    ) u_sram (
        .clk      (clk_i),
        .rd_index (index_s),
        .rd_data  (rd_line_s),
        .wr_en    (sram_we_s),
        .wr_index (index_s),
        .wr_mask  (sram_mask_s),
        .wr_data  (sram_wdata_s)
    );

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: behavioural line memory with a
// programmable ack delay, a table of hit vectors, and hand-written miss,
// write-back, reset and spurious-ack sequences.
module tb_dcache_ctrl;

    localparam int LIMIT = 300;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         p1_req_i;
    logic         p1_write_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .p1_req_i     (p1_req_i),
        .p1_write_i   (p1_write_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- memory model ----------------
    logic [255:0] mem_lines [logic [31:0]];
    int           delay   = 10;
    bit           auto_on = 1'b1;
    int           cnt     = 0;
    logic         ack_auto = 1'b0;
    logic         ack_man  = 1'b0;
    int           n_req = 0, n_wb = 0, n_rf = 0, wb_seq = 0, rf_seq = 0;
    logic [31:0]  wb_addr = '0, rf_addr = '0;
    logic [255:0] wb_data = '0;

    assign mem_ack_i = ack_auto | ack_man;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] la);
        logic [255:0] l;
        l = '0;
        if (mem_lines.exists(la)) l = mem_lines[la];
        else for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat(la + 32'(w * 4));
        return l;
    endfunction

    // Acks each request on its delay-th cycle of mem_enable_o.
    always @(negedge clk) begin
        ack_auto = 1'b0;
        if (auto_on && mem_enable_o && !rst_i) begin
            cnt = cnt + 1;
            if (cnt >= delay) begin
                cnt = 0;
                ack_auto = 1'b1;
                n_req = n_req + 1;
                if (mem_write_o) begin
                    n_wb = n_wb + 1; wb_seq = n_req;
                    wb_addr = mem_addr_o; wb_data = mem_data_o;
                    mem_lines[mem_addr_o] = mem_data_o;
                end else begin
                    n_rf = n_rf + 1; rf_seq = n_req;
                    rf_addr = mem_addr_o;
                    mem_data_i = line_of(mem_addr_o);
                end
            end
        end else begin
            cnt = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Holds one access until the stall clears; returns stall cycles and load data.
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output logic [31:0] rdata);
        @(posedge clk); #1;
        p1_req_i = 1'b1; p1_write_i = wr; p1_addr_i = a; p1_data_i = d;
        stalls = 0;
        @(negedge clk);
        while (p1_stall_o && stalls < LIMIT) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= LIMIT) begin
            total++; bad++;
            $display("FAIL access timeout addr=%0h stalls=%0d", a, stalls);
        end
        rdata = p1_data_o;
        @(posedge clk); #1;
        p1_req_i = 1'b0; p1_write_i = 1'b0;
    endtask

    typedef struct {
        logic        req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_stall;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int           st;
        logic [31:0]  rd;
        logic [255:0] l40_line, l80_line, tmp;
        int           wb0, rf0;

        rst_i = 1'b1; p1_req_i = 1'b0; p1_write_i = 1'b0;
        p1_addr_i = '0; p1_data_i = '0;

        tmp = line_of(32'h40);
        tmp[31:0] = 32'h1234_5678;
        mem_lines[32'h40] = tmp;
        // Expected dirty 0x40 line after the stores below.
        l40_line = tmp;
        l40_line[63:32]   = 32'hDEAD_BEEF;
        l40_line[255:224] = 32'h0BAD_F00D;
        l80_line = line_of(32'h80);
        l80_line[31:0] = 32'hCAFE_F00D;

        vecs[0] = '{1'b1, 1'b1, 32'h44, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h44, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b0, 32'h40, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b0, 32'h44, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h48, 32'h0,         1'b0, 1'b1, pat(32'h48)};
        vecs[5] = '{1'b1, 1'b1, 32'h5C, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'h5C, 32'h0,         1'b0, 1'b1, 32'h0BAD_F00D};
        vecs[7] = '{1'b1, 1'b0, 32'h58, 32'h0,         1'b0, 1'b1, pat(32'h58)};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst stall", p1_stall_o, 1'b0);
        chk("rst mem_enable", mem_enable_o, 1'b0);
        chk("rst mem_write", mem_write_o, 1'b0);
        chk("rst mem_addr", mem_addr_o, 32'h0);
        chk("rst mem_data", mem_data_o, 256'h0);
        chk("rst p1_data", p1_data_o, 32'h0);

        // Cold read miss, ack after 10 cycles
        delay = 10;
        access(1'b0, 32'h40, 32'h0, st, rd);
        chk("cold stalls", st, 12);
        chk("cold data", rd, 32'h1234_5678);
        chk("cold refills", n_rf, 1);
        chk("cold writebacks", n_wb, 0);
        chk("cold refill addr", rf_addr, 32'h40);

        // Hit vectors: no stall, no memory traffic
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            p1_req_i = vecs[i].req; p1_write_i = vecs[i].wr;
            p1_addr_i = vecs[i].addr; p1_data_i = vecs[i].data;
            @(negedge clk);
            chk($sformatf("vec%0d stall", i), p1_stall_o, vecs[i].exp_stall);
            chk($sformatf("vec%0d mem_enable", i), mem_enable_o, 1'b0);
            if (vecs[i].chk_data) chk($sformatf("vec%0d data", i), p1_data_o, vecs[i].exp_data);
        end
        @(posedge clk); #1;
        p1_req_i = 1'b0; p1_write_i = 1'b0;
        chk("hits refills", n_rf, 1);
        chk("hits writebacks", n_wb, 0);

        // Spurious ack in IDLE
        @(posedge clk); #1 ack_man = 1'b1;
        @(posedge clk); #1 ack_man = 1'b0;
        @(negedge clk);
        chk("spurious mem_enable", mem_enable_o, 1'b0);
        chk("spurious stall", p1_stall_o, 1'b0);
        access(1'b0, 32'h44, 32'h0, st, rd);
        chk("spurious hit stalls", st, 0);
        chk("spurious hit data", rd, 32'hDEAD_BEEF);

        // Dirty miss: same index, new tag
        delay = 3; wb0 = n_wb; rf0 = n_rf;
        access(1'b0, 32'h440, 32'h0, st, rd);
        chk("dirty stalls", st, 8);
        chk("dirty data", rd, pat(32'h440));
        chk("dirty wb count", n_wb - wb0, 1);
        chk("dirty rf count", n_rf - rf0, 1);
        chk("dirty wb addr", wb_addr, 32'h40);
        chk("dirty wb word1", wb_data[63:32], 32'hDEAD_BEEF);
        chk("dirty wb line", wb_data, l40_line);
        chk("dirty rf addr", rf_addr, 32'h440);
        chk("dirty order", rf_seq - wb_seq, 1);

        // Write miss: allocate, merge, dirty
        delay = 2; wb0 = n_wb;
        access(1'b1, 32'h80, 32'hCAFE_F00D, st, rd);
        chk("wmiss stalls", st, 4);
        chk("wmiss rf addr", rf_addr, 32'h80);
        chk("wmiss no wb", n_wb - wb0, 0);
        access(1'b0, 32'h80, 32'h0, st, rd);
        chk("wmiss word0", rd, 32'hCAFE_F00D);
        access(1'b0, 32'h84, 32'h0, st, rd);
        chk("wmiss word1", rd, pat(32'h84));
        access(1'b0, 32'h480, 32'h0, st, rd);
        chk("evict stalls", st, 6);
        chk("evict wb addr", wb_addr, 32'h80);
        chk("evict wb line", wb_data, l80_line);
        chk("evict data", rd, pat(32'h480));

        // Reset in the middle of REFILL
        auto_on = 1'b0; rf0 = n_rf; wb0 = n_wb;
        @(posedge clk); #1;
        p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h40;
        @(negedge clk);
        chk("rr miss stall", p1_stall_o, 1'b1);
        repeat (3) @(negedge clk);
        chk("rr mem_enable", mem_enable_o, 1'b1);
        chk("rr mem_write", mem_write_o, 1'b0);
        chk("rr mem_addr", mem_addr_o, 32'h40);
        @(posedge clk); #1;
        rst_i = 1'b1; p1_req_i = 1'b0;
        @(posedge clk); #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rr abort enable", mem_enable_o, 1'b0);
        chk("rr abort addr", mem_addr_o, 32'h0);
        chk("rr abort stall", p1_stall_o, 1'b0);
        @(posedge clk); #1 ack_man = 1'b1;
        @(posedge clk); #1 ack_man = 1'b0;
        @(negedge clk);
        chk("rr late ack enable", mem_enable_o, 1'b0);
        chk("rr late ack stall", p1_stall_o, 1'b0);
        auto_on = 1'b1; delay = 4;
        access(1'b0, 32'h40, 32'h0, st, rd);
        chk("rr re-miss stalls", st, 6);
        chk("rr re-miss data", rd, 32'h1234_5678);
        chk("rr re-miss refills", n_rf - rf0, 1);
        chk("rr re-miss no wb", n_wb - wb0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
